// File: rtl/key_schedule_stream.sv
// Round-key generator: emits a sliding window of three consecutive round keys,
// walking upward for encryption or, after a forward expansion, downward for decryption.
module key_schedule_stream #(
    parameter int W      = 8,
    parameter int ROUNDS = 96,
    parameter int ROT    = 3,
    parameter int IDX_W  = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             mode,
    input  logic [3*W-1:0]   key_in,
    input  logic             k_ready,
    output logic             busy,
    output logic             k_valid,
    output logic [W-1:0]     k_0,
    output logic [W-1:0]     k_1,
    output logic [W-1:0]     k_2,
    output logic [IDX_W-1:0] k_round,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_J     = IDX_W'(ROUNDS - 3);
    localparam logic [IDX_W-1:0] EXPAND_END = IDX_W'(ROUNDS - 4);
    localparam logic [IDX_W-1:0] ONE        = IDX_W'(1);

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
        return (x << ROT) | (x >> (W - ROT));
    endfunction

    state_t           state;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic [IDX_W-1:0] j;
    logic             mode_q;

    logic [IDX_W-1:0] j_prev;
    logic [W-1:0]     fwd_key;
    logic [W-1:0]     inv_key;
    logic             last_window;

    // The inverse step recovers K_(j-1), so it mixes in the index of the key being rebuilt.
    assign j_prev      = j - ONE;
    assign fwd_key     = rotl(c) ^ b ^ a ^ W'(j);
    assign inv_key     = c ^ rotl(b) ^ a ^ W'(j_prev);
    assign last_window = mode_q ? (j == '0) : (j == LAST_J);

    assign k_0     = a;
    assign k_1     = b;
    assign k_2     = c;
    assign k_round = j;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            j       <= '0;
            mode_q  <= 1'b0;
            busy    <= 1'b0;
            k_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a      <= key_in[W-1:0];
                        b      <= key_in[2*W-1:W];
                        c      <= key_in[3*W-1:2*W];
                        j      <= '0;
                        mode_q <= mode;
                        busy   <= 1'b1;
                        if (mode) begin
                            state <= EXPAND;
                        end else begin
                            state   <= EMIT;
                            k_valid <= 1'b1;
                        end
                    end
                end

                // Decrypt must first reach the final window before it can walk back down.
                EXPAND: begin
                    a <= b;
                    b <= c;
                    c <= fwd_key;
                    j <= j + ONE;
                    if (j == EXPAND_END) begin
                        state   <= EMIT;
                        k_valid <= 1'b1;
                    end
                end

                EMIT: begin
                    if (k_ready) begin
                        if (last_window) begin
                            state   <= IDLE;
                            k_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (!mode_q) begin
                            a <= b;
                            b <= c;
                            c <= fwd_key;
                            j <= j + ONE;
                        end else begin
                            a <= inv_key;
                            b <= a;
                            c <= b;
                            j <= j_prev;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    k_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_stream.sv
// Directed bench for key_schedule_stream: one 96-round instance and one 5-round
// instance, each scenario in its own task with inline comparisons.
module tb_key_schedule_stream;

    localparam int W   = 8;
    localparam int ROT = 3;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           mode;
    logic [3*W-1:0] key_in;
    logic           k_ready;
    logic           start_a;
    logic           start_b;

    logic           busy_a, k_valid_a, done_a;
    logic [W-1:0]   k_0_a, k_1_a, k_2_a;
    logic [6:0]     k_round_a;
    logic           busy_b, k_valid_b, done_b;
    logic [W-1:0]   k_0_b, k_1_b, k_2_b;
    logic [2:0]     k_round_b;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] kref [0:95];

    always #5 CLK = ~CLK;

    key_schedule_stream #(.W(W), .ROUNDS(96), .ROT(ROT), .IDX_W(7)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .start(start_a), .mode(mode), .key_in(key_in),
        .k_ready(k_ready), .busy(busy_a), .k_valid(k_valid_a), .k_0(k_0_a),
        .k_1(k_1_a), .k_2(k_2_a), .k_round(k_round_a), .done(done_a)
    );

    key_schedule_stream #(.W(W), .ROUNDS(5), .ROT(ROT), .IDX_W(3)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .start(start_b), .mode(mode), .key_in(key_in),
        .k_ready(k_ready), .busy(busy_b), .k_valid(k_valid_b), .k_0(k_0_b),
        .k_1(k_1_b), .k_2(k_2_b), .k_round(k_round_b), .done(done_b)
    );

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
        return (x << ROT) | (x >> (W - ROT));
    endfunction

    // Reference sequence K_0..K_95 built straight from the forward recurrence.
    task automatic build_ref(input logic [3*W-1:0] seed);
        kref[0] = seed[7:0];
        kref[1] = seed[15:8];
        kref[2] = seed[23:16];
        for (int i = 0; i < 93; i++) begin
            kref[i+3] = rotl(kref[i+2]) ^ kref[i+1] ^ kref[i] ^ 8'(i);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        k_ready = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        logic [33:0] obs;
        RST_N = 1'b0; start_a = 1'b0; start_b = 1'b0; k_ready = 1'b0;
        mode = 1'b0; key_in = '0;
        repeat (2) tick();
        obs = {busy_a, k_valid_a, done_a, k_0_a, k_1_a, k_2_a, k_round_a};
        checks++;
        if (obs !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_a: got %h expected 0", obs);
        end
        checks++;
        if ({busy_b, k_valid_b, done_b, k_0_b, k_1_b, k_2_b, k_round_b} !== 30'h0) begin
            errors++;
            $display("[TB] FAIL reset_b: got %h expected 0",
                     {busy_b, k_valid_b, done_b, k_0_b, k_1_b, k_2_b, k_round_b});
        end
        RST_N = 1'b1; key_in = 24'h030201; mode = 1'b0; k_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (2) tick();
        RST_N = 1'b0;
        repeat (2) tick();
        obs = {busy_a, k_valid_a, done_a, k_0_a, k_1_a, k_2_a, k_round_a};
        checks++;
        if (obs !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_emit: got %h expected 0", obs);
        end
        RST_N = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if ({busy_a, k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a} !== {2'b11, 24'h010203, 7'd0}) begin
            errors++;
            $display("[TB] FAIL restart_after_reset: got %h expected %h",
                     {busy_a, k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a}, {2'b11, 24'h010203, 7'd0});
        end
        do_reset();
    endtask

    task automatic test_encrypt();
        logic [32:0] exp_win [0:2];
        exp_win[0] = {1'b1, 8'h01, 8'h02, 8'h03, 8'd0};
        exp_win[1] = {1'b1, 8'h02, 8'h03, 8'h1B, 8'd1};
        exp_win[2] = {1'b1, 8'h03, 8'h1B, 8'hD8, 8'd2};
        key_in = 24'h030201; mode = 1'b0; k_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL enc_busy: got %b expected 1", busy_a);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({k_valid_a, k_0_a, k_1_a, k_2_a, 1'b0, k_round_a} !== exp_win[i]) begin
                errors++;
                $display("[TB] FAIL enc_window%0d: got %h expected %h", i,
                         {k_valid_a, k_0_a, k_1_a, k_2_a, 1'b0, k_round_a}, exp_win[i]);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_decrypt();
        logic [27:0] exp_win [0:2];
        exp_win[0] = {1'b1, 8'h03, 8'h1B, 8'hD8, 3'd2};
        exp_win[1] = {1'b1, 8'h02, 8'h03, 8'h1B, 3'd1};
        exp_win[2] = {1'b1, 8'h01, 8'h02, 8'h03, 3'd0};
        key_in = 24'h030201; mode = 1'b1; k_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if ({busy_b, k_valid_b} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL dec_expand1: got busy,valid=%b expected 10", {busy_b, k_valid_b});
        end
        tick();
        checks++;
        if (k_valid_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dec_expand2: got valid=%b expected 0", k_valid_b);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({k_valid_b, k_0_b, k_1_b, k_2_b, k_round_b} !== exp_win[i]) begin
                errors++;
                $display("[TB] FAIL dec_window%0d: got %h expected %h", i,
                         {k_valid_b, k_0_b, k_1_b, k_2_b, k_round_b}, exp_win[i]);
            end
            tick();
        end
        checks++;
        if ({done_b, k_valid_b, busy_b} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL dec_done: got done,valid,busy=%b expected 100",
                     {done_b, k_valid_b, busy_b});
        end
        tick();
        checks++;
        if (done_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dec_done_pulse: got %b expected 0", done_b);
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        int  exp_j;
        logic rdy;
        build_ref(24'h5A3C7E);
        key_in = 24'h5A3C7E; mode = 1'b0; k_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp_j = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            checks++;
            if ({k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a} !==
                {1'b1, kref[exp_j], kref[exp_j+1], kref[exp_j+2], 7'(exp_j)}) begin
                errors++;
                $display("[TB] FAIL bp_cycle%0d: got %h expected %h", cyc,
                         {k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a},
                         {1'b1, kref[exp_j], kref[exp_j+1], kref[exp_j+2], 7'(exp_j)});
            end
            rdy = !(cyc >= 3 && cyc < 7);
            k_ready = rdy;
            tick();
            if (rdy) exp_j++;
        end
        do_reset();
    endtask

    // Full encrypt run then full decrypt run with the same seed; start_pulse_j / expand_pulse
    // inject a spurious start (different mode and key) that must be ignored.
    task automatic full_run(input string tag, input logic [3*W-1:0] seed,
                            input int start_pulse_j, input int expand_pulse);
        int lat;
        build_ref(seed);
        key_in = seed; mode = 1'b0; k_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int jj = 0; jj < 94; jj++) begin
            checks++;
            if ({k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a} !==
                {1'b1, kref[jj], kref[jj+1], kref[jj+2], 7'(jj)}) begin
                errors++;
                $display("[TB] FAIL %s_enc_j%0d: got %h expected %h", tag, jj,
                         {k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a},
                         {1'b1, kref[jj], kref[jj+1], kref[jj+2], 7'(jj)});
            end
            if (jj == start_pulse_j) begin
                start_a = 1'b1; mode = 1'b1; key_in = ~seed;
            end else begin
                start_a = 1'b0; mode = 1'b0; key_in = seed;
            end
            tick();
        end
        start_a = 1'b0;
        checks++;
        if ({done_a, k_valid_a, busy_a} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL %s_enc_done: got done,valid,busy=%b expected 100", tag,
                     {done_a, k_valid_a, busy_a});
        end
        tick();
        key_in = seed; mode = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 1;
        while (!k_valid_a && lat < 200) begin
            if (lat == expand_pulse) begin
                start_a = 1'b1; mode = 1'b0; key_in = ~seed;
            end else begin
                start_a = 1'b0;
            end
            tick();
            lat++;
        end
        start_a = 1'b0;
        checks++;
        if (lat !== 94) begin
            errors++;
            $display("[TB] FAIL %s_dec_latency: got %0d expected 94", tag, lat);
        end
        for (int jj = 93; jj >= 0; jj--) begin
            checks++;
            if ({k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a} !==
                {1'b1, kref[jj], kref[jj+1], kref[jj+2], 7'(jj)}) begin
                errors++;
                $display("[TB] FAIL %s_dec_j%0d: got %h expected %h", tag, jj,
                         {k_valid_a, k_0_a, k_1_a, k_2_a, k_round_a},
                         {1'b1, kref[jj], kref[jj+1], kref[jj+2], 7'(jj)});
            end
            tick();
        end
        checks++;
        if ({done_a, k_valid_a, busy_a} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL %s_dec_done: got done,valid,busy=%b expected 100", tag,
                     {done_a, k_valid_a, busy_a});
        end
        tick();
    endtask

    task automatic test_round_trip();
        logic [3*W-1:0] seed;
        for (int s = 0; s < 3; s++) begin
            seed = 24'($urandom());
            full_run($sformatf("rt%0d", s), seed, -1, -1);
        end
        do_reset();
    endtask

    task automatic test_start_while_busy();
        full_run("swb", 24'hC0FFEE, 10, 5);
        do_reset();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_round_trip();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
